// File: rtl/frame_receiver.sv
// Asynchronous serial frame receiver: synchronised line, mid-bit sampling,
// optional parity, 1..2 stop bits, one-word holding register with valid/ready.
module frame_receiver #(
  parameter int DATA_W       = 10,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun,
  output logic              busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_IDLE
  } state_t;

  state_t            state_q, state_d;
  logic              sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  logic [CNT_W-1:0]  clk_cnt_q, clk_cnt_d;
  logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
  logic              stop_idx_q, stop_idx_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              perr_acc_q, perr_acc_d, ferr_acc_q, ferr_acc_d;
  logic              commit_q, commit_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              valid_q, valid_d, perr_q, perr_d, ferr_q, ferr_d;
  logic              overrun_q, overrun_d;

  logic line, fall, sample, half, last_stop;

  assign line      = sync2_q;
  assign fall      = prev_q & ~sync2_q;
  assign sample    = (clk_cnt_q == CNT_W'(CLKS_PER_BIT - 1));
  assign half      = (clk_cnt_q == CNT_W'(CLKS_PER_BIT / 2 - 1));
  assign last_stop = (STOP_BITS == 1) || stop_idx_q;

  always_comb begin
    sync1_d    = data_in;
    sync2_d    = sync1_q;
    prev_d     = sync2_q;
    state_d    = state_q;
    clk_cnt_d  = sample ? '0 : clk_cnt_q + 1'b1;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    shift_d    = shift_q;
    perr_acc_d = perr_acc_q;
    ferr_acc_d = ferr_acc_q;
    commit_d   = 1'b0;
    data_out_d = data_out_q;
    valid_d    = valid_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    overrun_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        clk_cnt_d = '0;
        if (fall) state_d = S_START;
      end
      S_START: begin
        if (half) begin
          clk_cnt_d = '0;
          if (!line) begin
            state_d    = S_DATA;
            bit_idx_d  = '0;
            perr_acc_d = 1'b0;
            ferr_acc_d = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (sample) begin
          shift_d[bit_idx_q] = line;
          if (bit_idx_q == IDX_W'(DATA_W - 1)) begin
            state_d    = (PARITY_EN != 0) ? S_PARITY : S_STOP;
            stop_idx_d = 1'b0;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (sample) begin
          perr_acc_d = (((^shift_q) ^ line) != (PARITY_ODD != 0));
          state_d    = S_STOP;
        end
      end
      S_STOP: begin
        if (sample) begin
          if (!line) ferr_acc_d = 1'b1;
          if (last_stop) begin
            commit_d = 1'b1;
            state_d  = line ? S_IDLE : S_WAIT_IDLE;
          end else begin
            stop_idx_d = 1'b1;
          end
        end
      end
      S_WAIT_IDLE: begin
        // A held-low (break) line must return high before a new start is accepted
        clk_cnt_d = '0;
        if (line) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (commit_q) begin
      if (!valid_q || data_ready) begin
        data_out_d = shift_q;
        perr_d     = perr_acc_q;
        ferr_d     = ferr_acc_q;
        valid_d    = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && data_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      prev_q     <= 1'b1;
      clk_cnt_q  <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      shift_q    <= '0;
      perr_acc_q <= 1'b0;
      ferr_acc_q <= 1'b0;
      commit_q   <= 1'b0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      prev_q     <= prev_d;
      clk_cnt_q  <= clk_cnt_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      shift_q    <= shift_d;
      perr_acc_q <= perr_acc_d;
      ferr_acc_q <= ferr_acc_d;
      commit_q   <= commit_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      overrun_q  <= overrun_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_frame_receiver.sv
// Scoreboard bench for frame_receiver: two instances (10N1 and 10E2), expected
// frames queued at stimulus time and checked by a monitor at each handshake.
module tb_frame_receiver;

  localparam int CPB = 16;
  localparam int DW  = 10;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          perr;
    logic          ferr;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          line0, line1;
  logic [DW-1:0] dout0, dout1;
  logic          valid0, valid1, ready0, ready1;
  logic          perr0, perr1, ferr0, ferr1, ovr0, ovr1, busy0, busy1;

  logic rand_ready = 1'b0;
  logic fix0 = 1'b1, fix1 = 1'b1;
  logic rr0 = 1'b1, rr1 = 1'b1;

  assign ready0 = rand_ready ? rr0 : fix0;
  assign ready1 = rand_ready ? rr1 : fix1;

  exp_t q0[$];
  exp_t q1[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   ovr_cnt0 = 0, ovr_cnt1 = 0;
  int   vcyc0    = 0;

  always #5 clk = ~clk;

  frame_receiver #(.DATA_W(DW), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut0 (
    .clk(clk), .reset(reset), .data_in(line0), .data_out(dout0), .data_valid(valid0),
    .data_ready(ready0), .parity_err(perr0), .frame_err(ferr0), .overrun(ovr0), .busy(busy0)
  );

  frame_receiver #(.DATA_W(DW), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) dut1 (
    .clk(clk), .reset(reset), .data_in(line1), .data_out(dout1), .data_valid(valid1),
    .data_ready(ready1), .parity_err(perr1), .frame_err(ferr1), .overrun(ovr1), .busy(busy1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: word is the data as sent; even parity over data+parity bit; any 0 stop bit flags.
  function automatic exp_t model(input int sel, input logic [DW-1:0] d, input logic par,
                                 input logic s0, input logic s1);
    exp_t e;
    e.data = d;
    e.perr = (sel == 1) ? ((($countones(d) + int'(par)) % 2) != 0) : 1'b0;
    e.ferr = !s0 || (sel == 1 && !s1);
    return e;
  endfunction

  task automatic score(input int sel, input logic [DW-1:0] d, input logic pe, input logic fe);
    exp_t e;
    if (sel == 0) begin
      check("frame0_expected", 32'(q0.size() != 0), 32'd1);
      if (q0.size() == 0) return;
      e = q0.pop_front();
    end else begin
      check("frame1_expected", 32'(q1.size() != 0), 32'd1);
      if (q1.size() == 0) return;
      e = q1.pop_front();
    end
    check($sformatf("dut%0d_data", sel), 32'(d), 32'(e.data));
    check($sformatf("dut%0d_parity_err", sel), 32'(pe), 32'(e.perr));
    check($sformatf("dut%0d_frame_err", sel), 32'(fe), 32'(e.ferr));
    $display("frame dut%0d: data=0x%03h perr=%0b ferr=%0b", sel, d, pe, fe);
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (ovr0) ovr_cnt0++;
      if (ovr1) ovr_cnt1++;
      if (valid0) vcyc0++;
      if (valid0 && ready0) score(0, dout0, perr0, ferr0);
      if (valid1 && ready1) score(1, dout1, perr1, ferr1);
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      rr0 = 1'($urandom % 2);
      rr1 = 1'($urandom % 2);
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic set_line(input int sel, input logic v);
    if (sel == 0) line0 = v;
    else line1 = v;
  endtask

  task automatic hold_bit(input int sel, input logic v);
    set_line(sel, v);
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input int sel, input logic [DW-1:0] d, input logic par,
                           input logic s0, input logic s1);
    hold_bit(sel, 1'b0);
    for (int i = 0; i < DW; i++) hold_bit(sel, d[i]);
    if (sel == 1) hold_bit(sel, par);
    hold_bit(sel, s0);
    if (sel == 1) hold_bit(sel, s1);
  endtask

  task automatic send_frame(input int sel, input logic [DW-1:0] d, input logic par,
                            input logic s0, input logic s1, input bit deliver);
    if (deliver) begin
      if (sel == 0) q0.push_back(model(sel, d, par, s0, s1));
      else q1.push_back(model(sel, d, par, s0, s1));
    end
    send_bits(sel, d, par, s0, s1);
    set_line(sel, 1'b1);
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  initial begin
    int v_before;
    logic [DW-1:0] d;
    logic s0;
    logic s1;
    reset = 1'b0;
    line0 = 1'b1;
    line1 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_data_out0", 32'(dout0), 32'd0);
    check("rst_valid0", 32'(valid0), 32'd0);
    check("rst_flags0", {perr0, ferr0, ovr0}, 32'd0);
    check("rst_busy0", 32'(busy0), 32'd0);
    check("rst_valid1", 32'(valid1), 32'd0);
    check("rst_busy1", 32'(busy1), 32'd0);
    reset = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Basic frame, consumer always ready
    v_before = vcyc0;
    send_frame(0, 10'h2A5, 1'b0, 1'b1, 1'b1, 1'b1);
    check("t1_valid_cycles", 32'(vcyc0 - v_before), 32'd1);
    check("t1_data_after_consume", 32'(dout0), 32'h2A5);

    // Short low glitch: enters START, rejected at mid start bit
    set_line(0, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    set_line(0, 1'b1);
    check("t2_busy_during_glitch", 32'(busy0), 32'd1);
    repeat (20) @(posedge clk);
    #1;
    check("t2_busy_after_glitch", 32'(busy0), 32'd0);
    check("t2_valid_after_glitch", 32'(valid0), 32'd0);

    // Wrong even parity bit
    send_frame(1, 10'h003, 1'b1, 1'b1, 1'b1, 1'b1);
    check("t3_data", 32'(dout1), 32'h003);

    // Stop bit 0 followed by a long break
    q0.push_back(model(0, 10'h1C3, 1'b0, 1'b0, 1'b1));
    send_bits(0, 10'h1C3, 1'b0, 1'b0, 1'b1);
    set_line(0, 1'b0);
    repeat (100) @(posedge clk);
    #1;
    check("t4_wait_idle_busy", 32'(busy0), 32'd1);
    check("t4_frame_delivered", 32'(q0.size()), 32'd0);
    set_line(0, 1'b1);
    repeat (CPB) @(posedge clk);
    #1;
    check("t4_idle_after_break", 32'(busy0), 32'd0);

    // Overrun: second frame dropped while first is held
    fix0 = 1'b0;
    send_frame(0, 10'h155, 1'b0, 1'b1, 1'b1, 1'b1);
    send_frame(0, 10'h0AA, 1'b0, 1'b1, 1'b1, 1'b0);
    check("t5_valid_held", 32'(valid0), 32'd1);
    check("t5_data_held", 32'(dout0), 32'h155);
    check("t5_overrun_cycles", 32'(ovr_cnt0), 32'd1);
    fix0 = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("t5_valid_cleared", 32'(valid0), 32'd0);
    check("t5_data_kept", 32'(dout0), 32'h155);
    check("t5_consumed", 32'(q0.size()), 32'd0);

    // Asynchronous reset in the middle of data bit 4
    d = 10'h2C6;
    hold_bit(0, 1'b0);
    for (int i = 0; i < 4; i++) hold_bit(0, d[i]);
    set_line(0, d[4]);
    repeat (8) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("t6_rst_data_out0", 32'(dout0), 32'd0);
    check("t6_rst_busy0", 32'(busy0), 32'd0);
    check("t6_rst_valid0", 32'(valid0), 32'd0);
    check("t6_rst_data_out1", 32'(dout1), 32'd0);
    set_line(0, 1'b1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    send_frame(0, 10'h3FF, 1'b0, 1'b1, 1'b1, 1'b1);
    check("t6_data_after_reset", 32'(dout0), 32'h3FF);

    // Randomised frames with a randomly stalling consumer
    rand_ready = 1'b1;
    for (int n = 0; n < 12; n++) begin
      d  = DW'($urandom);
      s0 = 1'(($urandom % 4) != 0);
      send_frame(0, d, 1'b0, s0, 1'b1, 1'b1);
    end
    for (int n = 0; n < 12; n++) begin
      d  = DW'($urandom);
      s0 = 1'(($urandom % 4) != 0);
      s1 = 1'(($urandom % 4) != 0);
      send_frame(1, d, 1'($urandom % 2), s0, s1, 1'b1);
    end
    rand_ready = 1'b0;
    repeat (30) @(posedge clk);
    #1;

    check("end_queue0_empty", 32'(q0.size()), 32'd0);
    check("end_queue1_empty", 32'(q1.size()), 32'd0);
    check("end_overrun0_total", 32'(ovr_cnt0), 32'd1);
    check("end_overrun1_total", 32'(ovr_cnt1), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
